// File: rtl/qarma_tweak_sched.sv
// QARMA tweak schedule: accepts one tweak, then emits R round tweaks,
// stepping forward (h then LFSR) or backward (inverse LFSR then h^-1).
module qarma_tweak_sched #(
   parameter int N = 128,
   parameter int R = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N-1:0]           in_tweak,
   input  logic                   in_dir,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [N-1:0]           out_tweak,
   output logic [$clog2(R):0]     out_round,
   output logic                   out_last
);

   localparam int M   = N / 16;
   localparam int RW  = $clog2(R) + 1;
   localparam int TAP = (M == 4) ? 1 : 2;

   // Packed 4-bit tables, entry i at [63-4*i -: 4]
   localparam logic [63:0] HP = {
      4'd6, 4'd5, 4'd14, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3,
      4'd7, 4'd12, 4'd13, 4'd4, 4'd8, 4'd9, 4'd10, 4'd11};
   localparam logic [63:0] HI = {
      4'd4, 4'd5, 4'd6, 4'd7, 4'd11, 4'd1, 4'd0, 4'd8,
      4'd12, 4'd13, 4'd14, 4'd15, 4'd9, 4'd10, 4'd2, 4'd3};
   localparam logic [15:0] LC = 16'h291B;

   if (N != 64 && N != 128) begin : g_bad_n
      $error("qarma_tweak_sched: N must be 64 or 128");
   end
   if (R < 1) begin : g_bad_r
      $error("qarma_tweak_sched: R must be at least 1");
   end

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state, state_nx;
   logic [N-1:0]    tweak_reg, tweak_nx;
   logic [N-1:0]    fwd, bwd;
   logic [RW-1:0]   round, round_nx;
   logic            dir_reg, dir_nx;

   logic [M-1:0]    c  [16];
   logic [M-1:0]    hc [16];
   logic [M-1:0]    fc [16];
   logic [M-1:0]    lc [16];

   function automatic logic [M-1:0] lfsr_f(input logic [M-1:0] x);
      return {x[0] ^ x[TAP], x[M-1:1]};
   endfunction

   function automatic logic [M-1:0] lfsr_i(input logic [M-1:0] y);
      return {y[M-2:0], y[M-1] ^ y[TAP-1]};
   endfunction

   for (genvar i = 0; i < 16; i++) begin : g_cell
      assign c[i]  = tweak_reg[N-1-M*i -: M];
      assign hc[i] = c[HP[63-4*i -: 4]];
      assign fc[i] = LC[i] ? lfsr_f(hc[i]) : hc[i];
      assign lc[i] = LC[i] ? lfsr_i(c[i]) : c[i];
      assign fwd[N-1-M*i -: M] = fc[i];
      assign bwd[N-1-M*i -: M] = lc[HI[63-4*i -: 4]];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         tweak_reg <= '0;
         round     <= '0;
         dir_reg   <= 1'b0;
      end else begin
         state     <= state_nx;
         tweak_reg <= tweak_nx;
         round     <= round_nx;
         dir_reg   <= dir_nx;
      end
   end

   always_comb begin
      state_nx = state;
      tweak_nx = tweak_reg;
      round_nx = round;
      dir_nx   = dir_reg;
      unique case (state)
         IDLE: begin
            if (in_valid) begin
               state_nx = RUN;
               tweak_nx = in_tweak;
               dir_nx   = in_dir;
               round_nx = '0;
            end
         end
         RUN: begin
            if (out_ready) begin
               if (round == RW'(R - 1)) begin
                  state_nx = IDLE;
               end else begin
                  tweak_nx = dir_reg ? bwd : fwd;
                  round_nx = round + RW'(1);
               end
            end
         end
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == RUN);
   assign out_tweak = tweak_reg;
   assign out_round = round;
   assign out_last  = (state == RUN) && (round == RW'(R - 1));

endmodule

// File: tb/tb_qarma_tweak_sched.sv
// Scoreboard bench for qarma_tweak_sched over three configurations:
// N=64/R=2, N=128/R=8 and N=64/R=1.
module tb_qarma_tweak_sched;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         iv   [3];
   logic [127:0] itw  [3];
   logic         idr  [3];
   logic         ordy [3];

   logic         ov0, ir0, ol0;
   logic [63:0]  ot0;
   logic [1:0]   rd0;
   logic         ov1, ir1, ol1;
   logic [127:0] ot1;
   logic [3:0]   rd1;
   logic         ov2, ir2, ol2;
   logic [63:0]  ot2;
   logic [0:0]   rd2;

   localparam int NW [3] = '{64, 128, 64};
   localparam int RR [3] = '{2, 8, 1};
   localparam int H  [16] = '{6,5,14,15,0,1,2,3,7,12,13,4,8,9,10,11};
   localparam int HV [16] = '{4,5,6,7,11,1,0,8,12,13,14,15,9,10,2,3};
   localparam int LS [7]  = '{0,1,3,4,8,11,13};

   typedef struct {
      logic [127:0] t;
      int           k;
      logic         last;
   } exp_t;

   exp_t         q0 [$];
   exp_t         q1 [$];
   exp_t         q2 [$];
   int           n_chk = 0;
   int           n_fail = 0;
   bit           stall [3];
   int           force_dut = -1;
   logic [127:0] force_seq [$];

   qarma_tweak_sched #(.N(64), .R(2)) u0 (
      .clk(clk), .rst(rst),
      .in_valid(iv[0]), .in_ready(ir0),
      .in_tweak(itw[0][63:0]), .in_dir(idr[0]),
      .out_valid(ov0), .out_ready(ordy[0]),
      .out_tweak(ot0), .out_round(rd0), .out_last(ol0));

   qarma_tweak_sched #(.N(128), .R(8)) u1 (
      .clk(clk), .rst(rst),
      .in_valid(iv[1]), .in_ready(ir1),
      .in_tweak(itw[1]), .in_dir(idr[1]),
      .out_valid(ov1), .out_ready(ordy[1]),
      .out_tweak(ot1), .out_round(rd1), .out_last(ol1));

   qarma_tweak_sched #(.N(64), .R(1)) u2 (
      .clk(clk), .rst(rst),
      .in_valid(iv[2]), .in_ready(ir2),
      .in_tweak(itw[2][63:0]), .in_dir(idr[2]),
      .out_valid(ov2), .out_ready(ordy[2]),
      .out_tweak(ot2), .out_round(rd2), .out_last(ol2));

   task automatic check(input string tag, input logic [127:0] got,
                        input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got %h want %h", tag, got, exp);
      end
   endtask

   // Cell-level reference: forward LFSR written from its definition,
   // inverse obtained by exhaustive search over the cell values.
   function automatic logic [7:0] wf(input logic [7:0] x, input int m);
      if (m == 4) return {4'b0, x[0] ^ x[1], x[3:1]};
      return {x[0] ^ x[2], x[7:1]};
   endfunction

   function automatic logic [7:0] wi(input logic [7:0] y, input int m);
      for (int v = 0; v < (1 << m); v++)
         if (wf(8'(v), m) == y) return 8'(v);
      return 8'hxx;
   endfunction

   function automatic logic [127:0] step(input logic [127:0] t,
                                         input int n, input bit dir);
      int           m;
      logic [7:0]   msk;
      logic [7:0]   c [16];
      logic [7:0]   p [16];
      logic [127:0] r;
      m   = n / 16;
      msk = (m == 4) ? 8'h0F : 8'hFF;
      for (int i = 0; i < 16; i++)
         c[i] = 8'(t >> (n - m * (i + 1))) & msk;
      if (!dir) begin
         for (int i = 0; i < 16; i++) p[i] = c[H[i]];
         for (int j = 0; j < 7; j++) p[LS[j]] = wf(p[LS[j]], m);
      end else begin
         for (int j = 0; j < 7; j++) c[LS[j]] = wi(c[LS[j]], m);
         for (int i = 0; i < 16; i++) p[i] = c[HV[i]];
      end
      r = '0;
      for (int i = 0; i < 16; i++)
         r = r | (128'(p[i]) << (n - m * (i + 1)));
      return r;
   endfunction

   function automatic int qsize(input int d);
      case (d)
         0: return q0.size();
         1: return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic exp_t qfront(input int d);
      case (d)
         0: return q0[0];
         1: return q1[0];
         default: return q2[0];
      endcase
   endfunction

   task automatic qpop(input int d);
      case (d)
         0: void'(q0.pop_front());
         1: void'(q1.pop_front());
         default: void'(q2.pop_front());
      endcase
   endtask

   task automatic qpush(input int d, input exp_t e);
      case (d)
         0: q0.push_back(e);
         1: q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   function automatic logic rdy(input int d);
      case (d)
         0: return ir0;
         1: return ir1;
         default: return ir2;
      endcase
   endfunction

   task automatic push_sched(input int d, input logic [127:0] t0,
                             input logic dir);
      exp_t         e;
      logic [127:0] t;
      t = t0;
      for (int k = 0; k < RR[d]; k++) begin
         e.t    = (force_dut == d) ? force_seq.pop_front() : t;
         e.k    = k;
         e.last = (k == RR[d] - 1);
         qpush(d, e);
         t = step(t, NW[d], dir);
      end
      if (force_dut == d) force_dut = -1;
   endtask

   task automatic mon(input int d, input logic ov, input logic ir,
                      input logic [127:0] ot, input logic [3:0] rd,
                      input logic ol);
      exp_t         e;
      int           sz;
      logic [127:0] t;
      sz = qsize(d);
      check($sformatf("valid%0d", d), 128'(ov), 128'(sz != 0));
      check($sformatf("in_ready%0d", d), 128'(ir), 128'(!ov));
      if (ov && sz != 0) begin
         e = qfront(d);
         check($sformatf("tweak%0d_k%0d", d, e.k), ot, e.t);
         check($sformatf("round%0d", d), 128'(rd), 128'(e.k));
         check($sformatf("last%0d_k%0d", d, e.k), 128'(ol), 128'(e.last));
         if (ordy[d]) qpop(d);
      end
      if (iv[d] && ir) begin
         t = (NW[d] == 64) ? {64'b0, itw[d][63:0]} : itw[d];
         push_sched(d, t, idr[d]);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         q0.delete();
         q1.delete();
         q2.delete();
      end else begin
         mon(0, ov0, ir0, 128'(ot0), 4'(rd0), ol0);
         mon(1, ov1, ir1, ot1, rd1, ol1);
         mon(2, ov2, ir2, 128'(ot2), 4'(rd2), ol2);
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         for (int d = 0; d < 3; d++)
            ordy[d] = stall[d] ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic start(input int d, input logic [127:0] t,
                        input logic dir);
      int n;
      n = 0;
      @(posedge clk);
      #2;
      iv[d]  = 1'b1;
      itw[d] = t;
      idr[d] = dir;
      forever begin
         @(negedge clk);
         if (rdy(d)) break;
         n++;
         if (n > 200) begin
            check("accept_timeout", 128'(rdy(d)), 128'(1));
            break;
         end
      end
      @(posedge clk);
      #2;
      iv[d] = 1'b0;
   endtask

   task automatic wait_idle(input int d);
      int n;
      n = 0;
      forever begin
         @(posedge clk);
         #2;
         if (qsize(d) == 0) break;
         n++;
         if (n > 400) begin
            check("drain_timeout", 128'(qsize(d)), 128'(0));
            break;
         end
      end
      @(posedge clk);
      #2;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   logic [127:0] fs [8];

   initial begin
      rst = 1'b1;
      for (int d = 0; d < 3; d++) begin
         iv[d]    = 1'b0;
         itw[d]   = '0;
         idr[d]   = 1'b0;
         ordy[d]  = 1'b1;
         stall[d] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      @(negedge clk);
      check("rst_valid", 128'(ov1), 128'(0));
      check("rst_ready", 128'(ir1), 128'(1));
      check("rst_tweak", ot1, 128'(0));
      check("rst_round", 128'(rd1), 128'(0));
      check("rst_last", 128'(ol1), 128'(0));
      check("rst_tweak64", 128'(ot0), 128'(0));
      repeat (4) @(posedge clk);

      force_seq = '{128'hFFFFFFFFFFFFFFFF, 128'h77F77FFF7FF7F7FF};
      force_dut = 0;
      start(0, 128'hFFFFFFFFFFFFFFFF, 1'b0);
      wait_idle(0);

      force_seq = '{128'h0000100000000000, 128'h0000000000080000};
      force_dut = 0;
      start(0, 128'h0000100000000000, 1'b0);
      wait_idle(0);

      force_seq = '{128'h77F77FFF7FF7F7FF, 128'hFFFFFFFFFFFFFFFF};
      force_dut = 0;
      start(0, 128'h77F77FFF7FF7F7FF, 1'b1);
      wait_idle(0);

      start(2, {64'b0, rnd128() >> 64}, 1'b0);
      wait_idle(2);
      start(2, {64'b0, rnd128() >> 64}, 1'b1);
      wait_idle(2);

      fs[0] = rnd128();
      for (int k = 1; k < 8; k++) fs[k] = step(fs[k-1], 128, 1'b0);
      start(1, fs[0], 1'b0);
      wait_idle(1);
      force_seq.delete();
      for (int k = 0; k < 8; k++) force_seq.push_back(fs[7-k]);
      force_dut = 1;
      start(1, fs[7], 1'b1);
      wait_idle(1);

      stall[1] = 1'b1;
      start(1, rnd128(), 1'b0);
      wait_idle(1);
      start(1, rnd128(), 1'b1);
      wait_idle(1);
      stall[1] = 1'b0;

      start(1, rnd128(), 1'b0);
      begin
         int n;
         n = 0;
         forever begin
            @(negedge clk);
            if (ov1 && rd1 == 4'd3) break;
            n++;
            if (n > 50) begin
               check("mid_rst_timeout", 128'(rd1), 128'(3));
               break;
            end
         end
      end
      @(posedge clk);
      #2;
      rst = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_valid", 128'(ov1), 128'(0));
      check("mid_rst_ready", 128'(ir1), 128'(1));
      repeat (3) @(posedge clk);

      stall[0] = 1'b1;
      @(posedge clk);
      #2;
      iv[0] = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #2;
         itw[0] = rnd128();
         idr[0] = 1'($urandom_range(0, 1));
      end
      iv[0] = 1'b0;
      wait_idle(0);
      stall[0] = 1'b0;
      repeat (3) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
